spectrum_peak_picker: RTL
=========================

Name: spectrum_peak_picker

Overview:
- Sits directly downstream of the FFT magnitude stage.
- Drives that stage's bin `index`, consumes each `magnitude`/`magnitude_ready` result, and tracks the strongest bin per logarithmic frequency band (fingerprint constellation points).
- After a full 512-bin scan it emits one peak record per qualifying band over a valid/ready stream to the hash/landmark builder.

Parameters:
- MAGNITUDES_COUNT, 512, number of bins scanned per frame.
- MAGNITUDE_N, $clog2(MAGNITUDES_COUNT), bin address width; `index` is MAGNITUDE_N+1 bits.
- MAG_W, 16, magnitude width, treated as unsigned.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- index  out  MAGNITUDE_N+1  bin address presented to the magnitude stage.
- magnitude  in  MAG_W  magnitude of the bin currently at `index`.
- magnitude_ready  in  1  one-cycle pulse; `magnitude` is valid.
- done_all_processing  in  1  level from the magnitude stage: frame scan finished.
- threshold  in  MAG_W  minimum magnitude for a peak to qualify; static during a frame.
- peak_valid  out  1  peak record valid.
- peak_ready  in  1  consumer accepts the record.
- peak_band  out  3  band number, 0..BAND_COUNT-1.
- peak_bin  out  MAGNITUDE_N  bin of the peak.
- peak_mag  out  MAG_W  magnitude of the peak.
- frame_done  out  1  one-cycle pulse after the last record of a frame.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (reset=0, async): state=IDLE, index=0, peak_valid=0, peak_band/peak_bin/peak_mag=0, frame_done=0, busy=0, all band max/valid registers cleared.
- Band edges are exclusive upper bounds: 10, 20, 40, 80, 160, 512 (BAND_COUNT=6). A bin belongs to the first band whose edge exceeds it.
- States:
  - IDLE: index held at 0. The first magnitude_ready moves to SCAN and is processed as bin 0.
  - SCAN: on each magnitude_ready, the bin equal to the current `index` is compared and `index` increments on that same edge.
    - The new value must be visible the cycle after the pulse, because the upstream loop samples it 1 cycle later.
    - After bin 511, `index`=512, which terminates the upstream loop; go to WAIT_DONE.
  - WAIT_DONE: wait for done_all_processing=1, then go to EMIT with band pointer=0.
  - EMIT: walk the band pointer 0..5.
    - Bands with no qualifying bin are skipped at 1 band/cycle.
    - For a qualifying band, present the record with peak_valid=1; outputs hold stable until peak_valid&&peak_ready.
    - After band 5: pulse frame_done, index←0, clear band registers, go to IDLE.
- Compare rule: a bin qualifies if magnitude >= threshold and magnitude > the current band max (strict), so on ties the lowest bin wins. A band is "valid" once any bin qualifies.
- magnitude_ready in WAIT_DONE, EMIT, or IDLE-with-index≠0 is ignored and has no effect.
- peak_ready with peak_valid=0 has no effect. peak_valid never drops without a handshake.
- Reset mid-scan or mid-emit: immediate return to reset values; the partial frame is discarded.
- Latency: last magnitude_ready → first peak_valid = 2 cycles after done_all_processing is seen high, plus skipped bands.

Decomposition:
- Package `peak_picker_pkg`: BAND_COUNT, BAND_EDGES array, state enum (IDLE, SCAN, WAIT_DONE, EMIT), peak record struct {band, bin, mag}.
- Sub-module `band_lookup`: combinational bin→band index from BAND_EDGES. The FSM, compare and emission logic stay in the top.

Test Plan:
- All 512 bins magnitude=0, threshold=1 → index steps 0..512; no peak_valid; one frame_done pulse; index returns to 0.
- Ramp magnitude=bin, threshold=0 → records (0,9,9), (1,19,19), (2,39,39), (3,79,79), (4,159,159), (5,511,511) in order.
- Bins 12 and 15 both 300, rest 0, threshold=100 → single record band 1, bin 12, mag 300.
- Single peak in band 3, peak_ready held low 20 cycles → peak_valid and fields stable for all 20 cycles; exactly one transfer on release.
- Assert reset=0 at bin 200 → all outputs at reset values within the same cycle; a new full frame afterwards produces correct peaks.
- magnitude_ready pulse during EMIT with magnitude=0xFFFF → records unchanged; index stays 512 until frame_done.

Source files
------------

// File: rtl/peak_picker_pkg.sv
// rtl/peak_picker_pkg.sv - shared constants, band table, FSM states and peak record for the peak picker
package peak_picker_pkg;

  localparam int MAGNITUDES_COUNT = 512;
  localparam int MAGNITUDE_N      = $clog2(MAGNITUDES_COUNT);
  localparam int MAG_W            = 16;
  localparam int BAND_COUNT       = 6;

  // Exclusive upper bin bound of each logarithmic band; element 0 is the lowest band.
  localparam logic [BAND_COUNT-1:0][MAGNITUDE_N:0] BAND_EDGES = {
    10'd512, 10'd160, 10'd80, 10'd40, 10'd20, 10'd10
  };

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SCAN      = 2'd1,
    WAIT_DONE = 2'd2,
    EMIT      = 2'd3
  } state_t;

  typedef struct packed {
    logic [2:0]             band;
    logic [MAGNITUDE_N-1:0] bin;
    logic [MAG_W-1:0]       mag;
  } peak_rec_t;

endpackage

// File: rtl/band_lookup.sv
// rtl/band_lookup.sv - combinational map from FFT bin number to logarithmic band index
module band_lookup
  import peak_picker_pkg::*;
(
  input  logic [MAGNITUDE_N-1:0] bin,
  output logic [2:0]             band
);

  // Walk from the top band down so the lowest band whose edge exceeds the bin wins.
  always_comb begin
    band = 3'(BAND_COUNT - 1);
    for (int i = BAND_COUNT - 1; i >= 0; i--) begin
      if ({1'b0, bin} < BAND_EDGES[i]) begin
        band = 3'(i);
      end
    end
  end

endmodule

// File: rtl/spectrum_peak_picker.sv
// rtl/spectrum_peak_picker.sv - scans FFT magnitudes, keeps the strongest bin per band, streams peak records
module spectrum_peak_picker
  import peak_picker_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  output logic [MAGNITUDE_N:0]   index,
  input  logic [MAG_W-1:0]       magnitude,
  input  logic                   magnitude_ready,
  input  logic                   done_all_processing,
  input  logic [MAG_W-1:0]       threshold,
  output logic                   peak_valid,
  input  logic                   peak_ready,
  output logic [2:0]             peak_band,
  output logic [MAGNITUDE_N-1:0] peak_bin,
  output logic [MAG_W-1:0]       peak_mag,
  output logic                   frame_done,
  output logic                   busy
);

  state_t                                   state_q, state_d;
  logic [MAGNITUDE_N:0]                     index_q, index_d;
  logic [2:0]                               ptr_q, ptr_d;
  logic [BAND_COUNT-1:0][MAG_W-1:0]         max_q, max_d;
  logic [BAND_COUNT-1:0][MAGNITUDE_N-1:0]   bin_q, bin_d;
  logic [BAND_COUNT-1:0]                    vld_q, vld_d;
  peak_rec_t                                peak_q, peak_d;
  logic                                     peak_valid_q, peak_valid_d;
  logic                                     frame_done_q, frame_done_d;
  logic [2:0]                               cur_band;
  logic                                     sample;
  logic                                     advance;

  band_lookup u_band_lookup (
    .bin  (index_q[MAGNITUDE_N-1:0]),
    .band (cur_band)
  );

  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    ptr_d        = ptr_q;
    max_d        = max_q;
    bin_d        = bin_q;
    vld_d        = vld_q;
    peak_d       = peak_q;
    peak_valid_d = peak_valid_q;
    frame_done_d = 1'b0;
    sample       = 1'b0;
    advance      = 1'b0;

    case (state_q)
      IDLE: begin
        if (magnitude_ready && (index_q == '0)) begin
          sample  = 1'b1;
          index_d = index_q + 1'b1;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (magnitude_ready) begin
          sample  = 1'b1;
          index_d = index_q + 1'b1;
          if (index_q == (MAGNITUDE_N+1)'(MAGNITUDES_COUNT - 1)) begin
            state_d = WAIT_DONE;
          end
        end
      end
      WAIT_DONE: begin
        if (done_all_processing) begin
          ptr_d   = '0;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (peak_valid_q) begin
          if (peak_ready) begin
            peak_valid_d = 1'b0;
            advance      = 1'b1;
          end
        end else if (vld_q[ptr_q]) begin
          peak_valid_d = 1'b1;
          peak_d       = '{band: ptr_q, bin: bin_q[ptr_q], mag: max_q[ptr_q]};
        end else begin
          advance = 1'b1;
        end
        if (advance) begin
          if (ptr_q == 3'(BAND_COUNT - 1)) begin
            state_d      = IDLE;
            frame_done_d = 1'b1;
            index_d      = '0;
            max_d        = '0;
            bin_d        = '0;
            vld_d        = '0;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Strict greater-than keeps the lowest bin on ties.
    if (sample && (magnitude >= threshold) && (magnitude > max_q[cur_band])) begin
      max_d[cur_band] = magnitude;
      bin_d[cur_band] = index_q[MAGNITUDE_N-1:0];
      vld_d[cur_band] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      index_q      <= '0;
      ptr_q        <= '0;
      max_q        <= '0;
      bin_q        <= '0;
      vld_q        <= '0;
      peak_q       <= '0;
      peak_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      ptr_q        <= ptr_d;
      max_q        <= max_d;
      bin_q        <= bin_d;
      vld_q        <= vld_d;
      peak_q       <= peak_d;
      peak_valid_q <= peak_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign index      = index_q;
  assign peak_valid = peak_valid_q;
  assign peak_band  = peak_q.band;
  assign peak_bin   = peak_q.bin;
  assign peak_mag   = peak_q.mag;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != IDLE);

endmodule
